priority_fsm: RTL and testbench

- Channel-dump sequencer for the coder datapath.
- On arm, latches a bitmask of requested channels. Each dump strobe then releases exactly one pending channel, lowest index first, as a one-hot select to the downstream mux/serializer.
- Flags when nothing is pending and pulses when an armed cycle has fully drained.

---
 rtl/priority_fsm_pkg.sv | 14 +
 rtl/prio_enc_onehot.sv | 23 ++
 rtl/priority_fsm.sv | 88 ++++++++
 tb/tb_priority_fsm.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/priority_fsm_pkg.sv
// Shared types and defaults for the channel-dump sequencer.
package priority_fsm_pkg;

  // Default channel count for the coder datapath.
  localparam int N_CH_DEFAULT = 16;

  // Sequencer states; 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/prio_enc_onehot.sv
// Lowest-set-bit one-hot encoder: bit 0 has the highest priority.
// Output is zero when no request bit is set. Purely combinational.
module prio_enc_onehot #(
  parameter int N = 16
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot
);

  // lower_any[k] is high when any request bit below index k is set.
  logic [N:0] lower_any;

  assign lower_any[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      // A bit wins only if nothing of higher priority is requesting.
      assign onehot[gi]        = req[gi] & ~lower_any[gi];
      assign lower_any[gi + 1] = lower_any[gi] | req[gi];
    end
  endgenerate

endmodule

// File: rtl/priority_fsm.sv
// Channel-dump sequencer: latches a channel request mask on arm and
// releases one pending channel per dump strobe, lowest index first.
module priority_fsm
  import priority_fsm_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] ch_sel_i,
  input  logic            arm_i,
  input  logic            dump_i,
  output logic [N_CH-1:0] ch_sel_o,
  output logic            zero_o,
  output logic            cycle_done_o
);

  state_t          state_reg, state_next;
  logic [N_CH-1:0] pending_reg, pending_next;
  logic [N_CH-1:0] head;
  logic            arm_load;

  // Head channel of the pending set.
  prio_enc_onehot #(
    .N(N_CH)
  ) u_head_enc (
    .req    (pending_reg),
    .onehot (head)
  );

  // An arm with at least one channel requested starts a new dump cycle.
  assign arm_load = arm_i & (|ch_sel_i);

  // State and pending-mask registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  // Next-state logic; an arm always takes precedence over a dump.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    unique case (state_reg)
      IDLE: begin
        if (arm_load) begin
          pending_next = ch_sel_i;
          state_next   = ARMED;
        end
      end
      ARMED: begin
        if (arm_i) begin
          // Re-arm replaces the mask; an empty mask drops back silently.
          pending_next = ch_sel_i;
          state_next   = arm_load ? ARMED : IDLE;
        end else if (dump_i) begin
          pending_next = pending_reg & ~head;
          state_next   = (pending_next == '0) ? DONE : ARMED;
        end
      end
      DONE: begin
        if (arm_load) begin
          pending_next = ch_sel_i;
          state_next   = ARMED;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

  // Outputs decode registered state only; no input-to-output path.
  always_comb begin
    ch_sel_o     = (state_reg == ARMED) ? head : '0;
    zero_o       = (pending_reg == '0);
    cycle_done_o = (state_reg == DONE);
  end

endmodule

// File: tb/tb_priority_fsm.sv
// Randomized and directed bench for priority_fsm against a queue-based
// reference model of the pending channel list.
module tb_priority_fsm;

  localparam int N_CH = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N_CH-1:0] ch_sel_i = '0;
  logic            arm_i = 1'b0;
  logic            dump_i = 1'b0;
  logic [N_CH-1:0] ch_sel_o;
  logic            zero_o;
  logic            cycle_done_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: sorted list of pending channel indices,
  // whether channels are being presented, and the done pulse.
  int q[$];
  bit m_armed = 1'b0;
  bit m_done  = 1'b0;

  always #5 clk_i = ~clk_i;

  priority_fsm #(.N_CH(N_CH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ch_sel_i     (ch_sel_i),
    .arm_i        (arm_i),
    .dump_i       (dump_i),
    .ch_sel_o     (ch_sel_o),
    .zero_o       (zero_o),
    .cycle_done_o (cycle_done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [N_CH-1:0] model_sel();
    logic [N_CH-1:0] r;
    r = '0;
    if (m_armed && q.size() > 0) r[q[0]] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_armed = 1'b0;
    m_done  = 1'b0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic a, input logic [N_CH-1:0] m, input logic d);
    bit done_n;
    done_n = 1'b0;
    if (a) begin
      q.delete();
      for (int i = 0; i < N_CH; i++) if (m[i]) q.push_back(i);
      m_armed = (q.size() > 0);
    end else if (m_armed && d) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_armed = 1'b0;
        done_n  = 1'b1;
      end
    end
    m_done = done_n;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ch_sel"}, 32'(ch_sel_o), 32'(model_sel()));
    check({tag, ".zero"},   32'(zero_o),   32'(q.size() == 0));
    check({tag, ".done"},   32'(cycle_done_o), 32'(m_done));
  endtask

  task automatic step(input string tag, input logic a, input logic [N_CH-1:0] m, input logic d);
    @(negedge clk_i);
    arm_i    = a;
    ch_sel_i = m;
    dump_i   = d;
    @(posedge clk_i);
    model_edge(a, m, d);
    #1;
    check_outputs(tag);
    $display("txn %s arm=%0b mask=0x%04h dump=%0b -> sel=0x%04h zero=%0b done=%0b",
             tag, a, m, d, ch_sel_o, zero_o, cycle_done_o);
  endtask

  // Assert reset away from the clock edge and confirm it acts at once.
  task automatic do_reset(input string tag);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk_i);
    #1;
    check_outputs({tag, ".held"});
    @(negedge clk_i);
    rst_i    = 1'b0;
    arm_i    = 1'b0;
    dump_i   = 1'b0;
    ch_sel_i = '0;
  endtask

  initial begin
    #1;
    check("por.ch_sel", 32'(ch_sel_o), 32'h0);
    check("por.zero", 32'(zero_o), 32'h1);
    check("por.done", 32'(cycle_done_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Arm 0x0022 and drain it, plus one extra dump.
    step("a22", 1'b1, 16'h0022, 1'b0);
    check("a22.head0", 32'(ch_sel_o), 32'h0002);
    step("a22.d1", 1'b0, 16'h0000, 1'b1);
    check("a22.head1", 32'(ch_sel_o), 32'h0020);
    step("a22.d2", 1'b0, 16'h0000, 1'b1);
    check("a22.pulse", 32'(cycle_done_o), 32'h1);
    step("a22.d3", 1'b0, 16'h0000, 1'b1);
    check("a22.pulse_end", 32'(cycle_done_o), 32'h0);

    // Arm 0x8001 with dump held high three cycles.
    step("a8001", 1'b1, 16'h8001, 1'b0);
    step("a8001.d1", 1'b0, 16'hFFFF, 1'b1);
    check("a8001.head1", 32'(ch_sel_o), 32'h8000);
    step("a8001.d2", 1'b0, 16'h1234, 1'b1);
    step("a8001.d3", 1'b0, 16'h0000, 1'b1);

    // Empty arm and dump in IDLE.
    step("a0", 1'b1, 16'h0000, 1'b0);
    step("idle.dump", 1'b0, 16'h0000, 1'b1);
    check("idle.zero", 32'(zero_o), 32'h1);

    // Arm wins over a simultaneous dump.
    step("a0c", 1'b1, 16'h000C, 1'b0);
    step("rearm", 1'b1, 16'h0100, 1'b1);
    check("rearm.head", 32'(ch_sel_o), 32'h0100);
    step("rearm.d1", 1'b0, 16'h0000, 1'b1);
    step("rearm.idle", 1'b0, 16'h0000, 1'b0);

    // Full mask walk, then re-arm during the DONE cycle.
    step("aFFFF", 1'b1, 16'hFFFF, 1'b0);
    for (int i = 0; i < N_CH; i++) begin
      check("walk.head", 32'(ch_sel_o), 32'(1) << i);
      step("walk.dump", 1'b0, 16'h0000, 1'b1);
    end
    check("walk.pulse", 32'(cycle_done_o), 32'h1);
    step("done.rearm", 1'b1, 16'h0006, 1'b0);
    check("done.rearm.head", 32'(ch_sel_o), 32'h0002);

    // Reset mid-operation.
    do_reset("rst_mid");

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic            a, d;
      logic [N_CH-1:0] m;
      a = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = N_CH'(1) << $urandom_range(0, N_CH - 1);
        default: m = N_CH'($urandom);
      endcase
      if ($urandom_range(0, 149) == 0) do_reset("rnd.rst");
      else step("rnd", a, m, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
